ram: RTL and testbench

- Single-port 32-word x 32-bit synchronous-write, asynchronous-read memory.
- Used as a general-purpose scratch/data store on the system clock.
- One shared address bus serves both reads and writes.
- Access is gated by a block enable (ena) and a write enable (wena).

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram.sv | 61 ++++++
 tb/tb_ram.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the scratch RAM.
package ram_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage : ram_pkg

// File: rtl/ram.sv
// Single-port scratch RAM: synchronous write, zero-latency read on a shared
// address bus, gated by ena/wena. Optional macro RAM_READ_REG_EN registers
// data_out, giving a one-cycle read latency.
module ram
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wena,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    // An unknown ena/wena evaluates false in the if below, so it never writes.
    assign wr_en = ena && wena;
    assign rd_en = ena && !wena;

    // Storage: reset clears every word and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= data_in;
        end
    end

    // Read mux: the addressed word in read mode, zeros otherwise.
    always_comb begin
        rd_word = '0;
        if (rd_en) begin
            rd_word = mem[addr];
        end
    end

`ifdef RAM_READ_REG_EN
    // Registered read port: captures the read mux every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= rd_word;
        end
    end
`else
    assign data_out = rd_word;
`endif

endmodule : ram

// File: tb/tb_ram.sv
// Directed self-checking bench for ram; follows RAM_READ_REG_EN when defined.
module tb_ram;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int unsigned n_tests;
    int unsigned n_fail;

    ram dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .wena     (wena),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present a read of address a and check the value after the read latency.
    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        ena  = 1'b1;
        wena = 1'b0;
        addr = a;
`ifdef RAM_READ_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        check(tag, data_out, exp);
    endtask

    // One write cycle; data_out must read zero once the edge has passed.
    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic chk);
        ena     = 1'b1;
        wena    = 1'b1;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        if (chk) check("out_zero_in_write", data_out, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        base    = 32'hA5A5_0000;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        ena     = 1'b0;
        wena    = 1'b0;
        addr    = '0;
        data_in = '0;

        // Reset then sweep: all words zero
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out", data_out, 32'h0);
        for (int i = 0; i < 32; i++) read_check("reset_sweep", 5'(i), 32'h0);

        // Fill then read back
        for (int i = 0; i < 32; i++) write_word(5'(i), base + 32'(i), (i < 4));
        for (int i = 0; i < 32; i++) read_check("fill_readback", 5'(i), base + 32'(i));

`ifndef RAM_READ_REG_EN
        // Address changes mid-cycle show through with no clock edge
        ena  = 1'b1;
        wena = 1'b0;
        @(negedge clk);
        addr = 5'b10101;
        #1;
        check("async_addr21", data_out, 32'hA5A5_0015);
        addr = 5'b01011;
        #1;
        check("async_addr11", data_out, 32'hA5A5_000B);
        wena = 1'b1;
        #1;
        check("async_wena_zero", data_out, 32'h0);
`endif

        // Enable gating: disabled read is zero, disabled write is dropped
        ena  = 1'b0;
        wena = 1'b0;
        addr = 5'd5;
        @(posedge clk);
        #1;
        check("ena0_out", data_out, 32'h0);
        ena     = 1'b0;
        wena    = 1'b1;
        addr    = 5'd3;
        data_in = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("ena0_wena1_out", data_out, 32'h0);
        read_check("ena0_no_write", 5'd3, 32'hA5A5_0003);

        // Write then immediate read of the same word
        write_word(5'd31, 32'hCAFE_F00D, 1'b1);
        ena  = 1'b1;
        wena = 1'b0;
        addr = 5'd31;
`ifdef RAM_READ_REG_EN
        #1;
        check("regout_before_edge", data_out, 32'h0);
        @(posedge clk);
        #1;
        check("regout_after_edge", data_out, 32'hCAFE_F00D);
`else
        #1;
        check("comb_write_then_read", data_out, 32'hCAFE_F00D);
`endif
        read_check("neighbour_30", 5'd30, base + 32'd30);

        // Reset beats a same-cycle write; every word cleared
        rst     = 1'b1;
        ena     = 1'b1;
        wena    = 1'b1;
        addr    = 5'd7;
        data_in = 32'h1234_5678;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_check("rst_prio_addr7", 5'd7, 32'h0);
        read_check("rst_clear_addr31", 5'd31, 32'h0);
        read_check("rst_clear_addr0", 5'd0, 32'h0);

        // Post-reset write still works
        write_word(5'd7, 32'h0BAD_F00D, 1'b0);
        read_check("post_reset_write", 5'd7, 32'h0BAD_F00D);
        read_check("post_reset_other", 5'd8, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram
